// File: rtl/decifra_bloco_iterativa.sv
// Iterative decryption round engine: one 128-bit block per handshake,
// NUM_RODADAS rounds (rotate, substitute, key XOR, column mix), one per clock.
// Ports: clk, rst_n (async, active-low);
//   entrada_valida/entrada_pronta/bloco: input block handshake;
//   chave_expandida: round keys, word-interleaved, held from accept to output;
//   saida_valida/saida_pronta/saida: result handshake;
//   ocupado: high while rounds run; rodada_atual: round being applied.
// Build option: DECIFRA_ULTIMA_SEM_MIX_EN drops the column mix of the last round.
module decifra_bloco_iterativa #(
   parameter int NUM_RODADAS = 10
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       entrada_valida,
   output logic                       entrada_pronta,
   input  logic [127:0]               bloco,
   input  logic [128*NUM_RODADAS-1:0] chave_expandida,
   output logic                       saida_valida,
   input  logic                       saida_pronta,
   output logic [127:0]               saida,
   output logic                       ocupado,
   output logic [3:0]                 rodada_atual
);

   localparam logic [3:0] ULT = 4'(NUM_RODADAS - 1);

   typedef enum logic [1:0] {
      OCIOSO,
      RODANDO,
      COMPLETO
   } fsm_t;

   fsm_t         fsm_q;
   logic [127:0] estado_q;
   logic [127:0] estado_d;
   logic [3:0]   rodada_q;

   function automatic logic [7:0] xt(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(
      input logic [7:0] a,
      input logic [7:0] b
   );
      logic [7:0] p;
      logic [7:0] x;
      logic [7:0] y;
      p = 8'h00;
      x = a;
      y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = xt(x);
         y = y >> 1;
      end
      return p;
   endfunction

   // Field inverse as v^254, built by square-and-multiply; maps 0 to 0.
   function automatic logic [7:0] ginv(input logic [7:0] v);
      logic [7:0] p;
      logic [7:0] r;
      p = gmul(v, v);
      r = p;
      for (int i = 0; i < 6; i++) begin
         p = gmul(p, p);
         r = gmul(r, p);
      end
      return r;
   endfunction

   // Inverse substitution: inverse affine map, then field inverse.
   function automatic logic [7:0] isb(input logic [7:0] v);
      logic [7:0] a;
      a = {v[6:0], v[7]}
        ^ {v[4:0], v[7:5]}
        ^ {v[1:0], v[7:2]}
        ^ 8'h05;
      return ginv(a);
   endfunction

   function automatic logic [31:0] imix(input logic [31:0] c);
      logic [7:0] a [4];
      logic [7:0] m9 [4];
      logic [7:0] mb [4];
      logic [7:0] md [4];
      logic [7:0] me [4];
      logic [7:0] x2;
      logic [7:0] x4;
      logic [7:0] x8;
      a[0] = c[31:24];
      a[1] = c[23:16];
      a[2] = c[15:8];
      a[3] = c[7:0];
      for (int i = 0; i < 4; i++) begin
         x2 = xt(a[i]);
         x4 = xt(x2);
         x8 = xt(x4);
         m9[i] = x8 ^ a[i];
         mb[i] = x8 ^ x2 ^ a[i];
         md[i] = x8 ^ x4 ^ a[i];
         me[i] = x8 ^ x4 ^ x2;
      end
      return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
              m9[0] ^ me[1] ^ mb[2] ^ md[3],
              md[0] ^ m9[1] ^ me[2] ^ mb[3],
              mb[0] ^ md[1] ^ m9[2] ^ me[3]};
   endfunction

   // Round keys regrouped per round; unused slots are zero so a
   // plain 4-bit index selects the key.
   wire [127:0] rk_tab [16];

   for (genvar r = 0; r < 16; r++) begin : g_rk
      if (r < NUM_RODADAS) begin : g_on
         localparam int B0 = 128*NUM_RODADAS - 1 - 32*r;
         localparam int WS = 32*NUM_RODADAS;
         assign rk_tab[r] = {chave_expandida[B0 -: 32],
                             chave_expandida[B0 - WS -: 32],
                             chave_expandida[B0 - 2*WS -: 32],
                             chave_expandida[B0 - 3*WS -: 32]};
      end else begin : g_off
         assign rk_tab[r] = '0;
      end
   end

   wire [127:0] rot_w;
   wire [127:0] sub_w;
   wire [127:0] xor_w;
   wire [127:0] mix_w;

   // Byte i sits at bits [127-8i -: 8]; column c holds bytes 4c..4c+3.
   // Row r of every column is rotated right by r columns.
   for (genvar c = 0; c < 4; c++) begin : g_col
      for (genvar r = 0; r < 4; r++) begin : g_row
         localparam int DST = 4*c + r;
         localparam int SRC = 4*((c + 4 - r) % 4) + r;
         assign rot_w[127-8*DST -: 8] = estado_q[127-8*SRC -: 8];
      end
      assign mix_w[32*c +: 32] = imix(xor_w[32*c +: 32]);
   end

   for (genvar i = 0; i < 16; i++) begin : g_sub
      assign sub_w[8*i +: 8] = isb(rot_w[8*i +: 8]);
   end

   assign xor_w = sub_w ^ rk_tab[rodada_q];

`ifdef DECIFRA_ULTIMA_SEM_MIX_EN
   assign estado_d = (rodada_q == ULT) ? xor_w : mix_w;
`else
   assign estado_d = mix_w;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm_q    <= OCIOSO;
         estado_q <= '0;
         rodada_q <= '0;
      end else begin
         unique case (fsm_q)
            OCIOSO: begin
               if (entrada_valida) begin
                  estado_q <= bloco;
                  rodada_q <= '0;
                  fsm_q    <= RODANDO;
               end
            end
            RODANDO: begin
               estado_q <= estado_d;
               if (rodada_q == ULT) begin
                  rodada_q <= '0;
                  fsm_q    <= COMPLETO;
               end else begin
                  rodada_q <= rodada_q + 4'd1;
               end
            end
            COMPLETO: begin
               if (saida_pronta) begin
                  if (entrada_valida) begin
                     estado_q <= bloco;
                     rodada_q <= '0;
                     fsm_q    <= RODANDO;
                  end else begin
                     fsm_q <= OCIOSO;
                  end
               end
            end
            default: begin
               fsm_q <= OCIOSO;
            end
         endcase
      end
   end

   assign entrada_pronta = (fsm_q == OCIOSO)
                         | ((fsm_q == COMPLETO) & saida_pronta);
   assign ocupado        = (fsm_q == RODANDO);
   assign saida_valida   = (fsm_q == COMPLETO);
   assign saida          = estado_q;
   assign rodada_atual   = rodada_q;

endmodule
